// File: rtl/mod_butterfly_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mod_butterfly_pipe
//  Brief    : Pipelined (a+b) mod q / (a-b) mod q butterfly leg with
//             valid/ready backpressure and a retired-transaction counter.
//             Optional range check enabled by defining MOD_RANGE_CHK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module mod_butterfly_pipe #(
   parameter int W      = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [W-1:0]     q,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out0,
   output logic [W-1:0]     out1,
   output logic [1:0]       out_mode,
   output logic [CNT_W-1:0] done_cnt
`ifdef MOD_RANGE_CHK_EN
   ,
   output logic             err,
   output logic             err_sticky
`endif
);

   localparam logic [1:0] c_MODE_SUB  = 2'b01;
   localparam logic [1:0] c_MODE_BFLY = 2'b10;

   logic [STAGES-1:0] r_valid;
   logic [STAGES-1:0] w_adv;

   logic [W:0]        r_sum0;
   logic [W-1:0]      r_dif0;
   logic [W-1:0]      r_q0;
   logic [1:0]        r_mode0;
   logic              r_lt0;

   logic [W-1:0]      w_sum_red;
   logic [W-1:0]      w_dif_red;
   logic [W-1:0]      w_res0;
   logic [W-1:0]      w_res1;

   logic [W-1:0]      r_res0 [1:STAGES-1];
   logic [W-1:0]      r_res1 [1:STAGES-1];
   logic [1:0]        r_mode [1:STAGES-1];

   logic [CNT_W-1:0]  r_done_cnt;
   logic              w_retire;

   // A stage may move when it or any stage downstream of it has a hole,
   // or when the output is being drained this cycle.
   always_comb begin
      logic w_full;
      w_full = 1'b1;
      w_adv  = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         w_full   = w_full & r_valid[k];
         w_adv[k] = out_ready | ~w_full;
      end
   end

   assign in_ready  = w_adv[0];
   assign out_valid = r_valid[STAGES-1];
   assign w_retire  = r_valid[STAGES-1] & out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
      end else begin
         if (w_adv[0]) r_valid[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) begin
            if (w_adv[k]) r_valid[k] <= r_valid[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sum0  <= '0;
         r_dif0  <= '0;
         r_q0    <= '0;
         r_mode0 <= '0;
         r_lt0   <= 1'b0;
      end else if (w_adv[0]) begin
         r_sum0  <= {1'b0, a} + {1'b0, b};
         r_dif0  <= a - b;
         r_q0    <= q;
         r_mode0 <= mode;
         r_lt0   <= (a < b);
      end
   end

   // Subtracting q from the W+1-bit sum only needs the low W bits of the result.
   always_comb begin
      w_sum_red = r_sum0[W-1:0];
      if (r_sum0 >= {1'b0, r_q0}) w_sum_red = r_sum0[W-1:0] - r_q0;
      w_dif_red = r_lt0 ? (r_dif0 + r_q0) : r_dif0;
      w_res0    = (r_mode0 == c_MODE_SUB)  ? w_dif_red : w_sum_red;
      w_res1    = (r_mode0 == c_MODE_BFLY) ? w_dif_red : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 1; k < STAGES; k++) begin
            r_res0[k] <= '0;
            r_res1[k] <= '0;
            r_mode[k] <= '0;
         end
      end else begin
         if (w_adv[1]) begin
            r_res0[1] <= w_res0;
            r_res1[1] <= w_res1;
            r_mode[1] <= r_mode0;
         end
         for (int k = 2; k < STAGES; k++) begin
            if (w_adv[k]) begin
               r_res0[k] <= r_res0[k-1];
               r_res1[k] <= r_res1[k-1];
               r_mode[k] <= r_mode[k-1];
            end
         end
      end
   end

   assign out0     = r_res0[STAGES-1];
   assign out1     = r_res1[STAGES-1];
   assign out_mode = r_mode[STAGES-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_done_cnt <= '0;
      end else if (w_retire) begin
         r_done_cnt <= r_done_cnt + 1'b1;
      end
   end

   assign done_cnt = r_done_cnt;

`ifdef MOD_RANGE_CHK_EN
   logic r_err0;
   logic r_err [1:STAGES-1];
   logic r_err_sticky;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err0 <= 1'b0;
         for (int k = 1; k < STAGES; k++) r_err[k] <= 1'b0;
      end else begin
         if (w_adv[0]) r_err0 <= (a >= q) | (b >= q);
         if (w_adv[1]) r_err[1] <= r_err0;
         for (int k = 2; k < STAGES; k++) begin
            if (w_adv[k]) r_err[k] <= r_err[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err_sticky <= 1'b0;
      end else if (w_retire & r_err[STAGES-1]) begin
         r_err_sticky <= 1'b1;
      end
   end

   assign err        = r_err[STAGES-1];
   assign err_sticky = r_err_sticky;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_butterfly_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_butterfly_pipe
//  Brief    : Self-checking bench for mod_butterfly_pipe (directed + random).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mod_butterfly_pipe;
   localparam int W      = 8;
   localparam int STAGES = 2;
   localparam int CNT_W  = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       mode;
   logic [W-1:0]     q;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out0;
   logic [W-1:0]     out1;
   logic [1:0]       out_mode;
   logic [CNT_W-1:0] done_cnt;
`ifdef MOD_RANGE_CHK_EN
   logic             err;
   logic             err_sticky;
`endif

   mod_butterfly_pipe #(.W(W), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .q         (q),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out0      (out0),
      .out1      (out1),
      .out_mode  (out_mode),
      .done_cnt  (done_cnt)
`ifdef MOD_RANGE_CHK_EN
      ,
      .err       (err),
      .err_sticky(err_sticky)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] o0;
      logic [W-1:0] o1;
      logic [1:0]   m;
      logic         e;
      int           acc;
      logic         stalled;
   } txn_t;

   txn_t             exp_q[$];
   int               retired_log[$];
   int               n_pass = 0;
   int               n_total = 0;
   int               cyc = 0;
   logic [CNT_W-1:0] mdl_cnt = '0;
   logic             mdl_sticky = 1'b0;
   logic             prev_hold = 1'b0;
   logic [W-1:0]     prev0 = '0;
   logic [W-1:0]     prev1 = '0;
   logic [1:0]       prevm = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reduced results for in-range operands; the raw correction formula otherwise.
   function automatic txn_t model(input logic [1:0] m, input int av, input int bv, input int qv);
      txn_t t;
      int   s;
      int   d;
      if (av < qv && bv < qv) begin
         s = (av + bv) % qv;
         d = (av - bv + qv) % qv;
      end else begin
         s = (av + bv >= qv) ? av + bv - qv : av + bv;
         d = (av < bv) ? av - bv + qv : av - bv;
      end
      t.o0      = (m == 2'b01) ? d[W-1:0] : s[W-1:0];
      t.o1      = (m == 2'b10) ? d[W-1:0] : '0;
      t.m       = m;
      t.e       = (av >= qv) || (bv >= qv);
      t.acc     = 0;
      t.stalled = 1'b0;
      return t;
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!reset) begin
         check("out_valid_in_reset", out_valid, 0);
         exp_q.delete();
         mdl_cnt    = '0;
         mdl_sticky = 1'b0;
         prev_hold  = 1'b0;
      end else begin
         check("done_cnt", done_cnt, mdl_cnt);
`ifdef MOD_RANGE_CHK_EN
         check("err_sticky", err_sticky, mdl_sticky);
`endif
         if (prev_hold && out_valid) begin
            check("hold_out0", out0, prev0);
            check("hold_out1", out1, prev1);
            check("hold_mode", out_mode, prevm);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", out_valid, 0);
            end else begin
               txn_t t;
               t = exp_q.pop_front();
               check("out0", out0, t.o0);
               check("out1", out1, t.o1);
               check("out_mode", out_mode, t.m);
`ifdef MOD_RANGE_CHK_EN
               check("err", err, t.e);
               if (t.e) mdl_sticky = 1'b1;
`endif
               if (!t.stalled) check("latency", cyc - t.acc, STAGES);
               mdl_cnt = mdl_cnt + 1'b1;
               retired_log.push_back(int'(out0));
            end
         end
         if (!out_ready) begin
            for (int i = 0; i < exp_q.size(); i++) exp_q[i].stalled = 1'b1;
         end
         if (in_valid && in_ready) begin
            txn_t t;
            t     = model(mode, int'(a), int'(b), int'(q));
            t.acc = cyc;
            exp_q.push_back(t);
         end
         prev_hold = out_valid && !out_ready;
         prev0     = out0;
         prev1     = out1;
         prevm     = out_mode;
      end
   end

   task automatic send(input logic [1:0] m, input int av, input int bv);
      int n;
      n        = 0;
      mode     = m;
      a        = W'(av);
      b        = W'(bv);
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string name, input int e0, input int e1, input logic [1:0] em);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({name, "_valid"}, out_valid, 1);
      check({name, "_out0"}, out0, e0);
      check({name, "_out1"}, out1, e1);
      check({name, "_mode"}, out_mode, em);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      retired_log.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int acc;
      int n;
      int qv;
      logic taken;

      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      mode      = 2'b00;
      q         = W'(251);
      a         = '0;
      b         = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out0", out0, 0);
      check("rst_out1", out1, 0);
      check("rst_out_mode", out_mode, 0);
      check("rst_done_cnt", done_cnt, 0);
      reset = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Worked examples with q = 251.
      send(2'b00, 200, 100);
      expect_out("add", 49, 0, 2'b00);
      @(negedge clk);
      check("add_done_cnt", done_cnt, 1);
      @(posedge clk);
      #1;
      send(2'b01, 10, 20);
      expect_out("sub_wrap", 241, 0, 2'b01);
      send(2'b01, 20, 10);
      expect_out("sub", 10, 0, 2'b01);
      send(2'b10, 250, 1);
      expect_out("bfly", 0, 249, 2'b10);
      send(2'b10, 0, 0);
      expect_out("bfly_zero", 0, 0, 2'b10);
      send(2'b11, 3, 5);
      expect_out("mode11", 8, 0, 2'b11);

      // Backpressure: pipeline fills at STAGES entries and holds its output.
      do_reset();
      out_ready = 1'b0;
      idx       = 1;
      acc       = 0;
      mode      = 2'b00;
      a         = W'(1);
      b         = W'(1);
      in_valid  = 1'b1;
      repeat (6) begin
         @(negedge clk);
         taken = in_ready;
         if (taken) acc++;
         @(posedge clk);
         #1;
         if (taken) begin
            idx++;
            a = W'(idx);
            b = W'(idx);
         end
      end
      check("bp_accepts", acc, STAGES);
      check("bp_in_ready_low", in_ready, 0);
      out_ready = 1'b1;
      n = 0;
      while (idx <= 5 && n < 30) begin
         @(negedge clk);
         taken = in_ready;
         @(posedge clk);
         #1;
         n++;
         if (taken) begin
            idx++;
            if (idx > 5) in_valid = 1'b0;
            a = W'(idx);
            b = W'(idx);
         end
      end
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("bp_count", retired_log.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < retired_log.size()) check("bp_order", retired_log[i], 2 * (i + 1));
      end
      @(negedge clk);
      check("bp_done_cnt", done_cnt, 5);
      @(posedge clk);
      #1;

      // Reset with two transactions in flight.
      mode     = 2'b00;
      a        = W'(7);
      b        = W'(8);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      a = W'(9);
      b = W'(1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      reset    = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_done_cnt", done_cnt, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("stale_out", out_valid, 0);
      end
      @(posedge clk);
      #1;

      // Random traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         qv        = int'($urandom_range(255, 2));
         q         = W'(qv);
         a         = W'($urandom_range(qv - 1, 0));
         b         = W'($urandom_range(qv - 1, 0));
         mode      = 2'($urandom_range(3, 0));
         in_valid  = ($urandom_range(9, 0) < 7);
         out_ready = ($urandom_range(9, 0) < 7);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("drain_empty", exp_q.size(), 0);

`ifdef MOD_RANGE_CHK_EN
      q = W'(251);
      send(2'b00, 255, 0);
      expect_out("range_err", 4, 0, 2'b00);
      @(negedge clk);
      check("sticky_set", err_sticky, 1);
      @(posedge clk);
      #1;
      send(2'b00, 3, 4);
      expect_out("after_err", 7, 0, 2'b00);
      @(negedge clk);
      check("sticky_hold", err_sticky, 1);
      @(posedge clk);
      #1;
      do_reset();
      #1;
      check("sticky_cleared", err_sticky, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
